regfile_trace_buffer: RTL
=========================

# regfile_trace_buffer

Synthesizable, parametrised write-back trace capture unit for the openmips core. Taps the register-file write port(s) together with the current pc and inst, and records each retired register write into an on-chip circular buffer. Supports free-run, stop-when-full and pc-triggered modes, and offers a valid/ready readout port, so traces can be captured on the board rather than only dumped in simulation.

## Interface
- DATA_W, 32, width of pc, inst and write data
- RADDR_W, 5, register address width
- DEPTH, 64, entries in the ring; power of two, at least 4
- NPORT, 1, number of register write ports traced (1..4)
- FILTER_R0, 1, when 1, writes to register 0 are ignored
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- en  in  1  capture enable
- mode  in  2  0 = WRAP, 1 = STOP_FULL, 2 = TRIGGER, 3 = reserved (treated as WRAP)
- clear  in  1  synchronous flush of buffer, counters and state
- trig_pc  in  DATA_W  pc value that fires the trigger in TRIGGER mode
- post_cnt  in  $clog2(DEPTH)+1  captures to take after the trigger
- pc_i, inst_i  in  DATA_W  pc and instruction accompanying the write-back
- we_i  in  NPORT  per-port write enable
- waddr_i  in  NPORT*RADDR_W  per-port write address; port k occupies bits [k*RADDR_W +: RADDR_W]
- wdata_i  in  NPORT*DATA_W  per-port write data
- rd_valid  out  1  head entry available
- rd_ready  in  1  pop head entry
- rd_pc, rd_inst, rd_wdata  out  DATA_W  head entry fields
- rd_waddr  out  RADDR_W  head entry register address
- rd_port  out  max(1,$clog2(NPORT))  port index that produced the head entry
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count == DEPTH
- triggered  out  1  trigger has fired since last clear
- done  out  1  capture finished (state DONE)
- dropped  out  16  saturating count of lost captures

## Operation
- Qualified port k: `we_i[k]`, and also `waddr != 0` when FILTER_R0 = 1. Only the lowest-index qualified port is captured each cycle. Every other qualified port increments `dropped`.
- Push occurs when the state is CAPTURE or POST and a qualified port exists.
- States and transitions:
  - IDLE to CAPTURE when `en` = 1.
  - CAPTURE or POST to IDLE when `en` = 0. Buffer contents and post counter are retained.
  - CAPTURE to POST in TRIGGER mode when `en` = 1 and `pc_i == trig_pc`. This sets `triggered` and loads the post counter with `post_cnt`. If `post_cnt` = 0, go directly to DONE; the trigger cycle itself is not captured in that case.
  - POST: each push decrements the counter. The push that brings it to 0 moves the block to DONE.
  - CAPTURE to DONE in STOP_FULL mode on the push that makes count == DEPTH.
  - DONE is left only on `clear` or `rst`.
- Full-buffer behaviour:
  - WRAP and TRIGGER: a push into a full buffer overwrites the oldest entry (head advances). `dropped` is not incremented.
  - STOP_FULL: a push into a full buffer cannot occur, because the block is already in DONE.
  - A qualified write arriving in IDLE or DONE is not counted as dropped.
- Pop: `rd_valid && rd_ready` advances the head. Pops are allowed in any state.
- Push and pop in the same cycle: count is unchanged. When full, this is a normal push plus pop, not an overwrite.
- `rd_valid` = (count != 0). All `rd_*` data outputs are 0 when `rd_valid` = 0.
- `clear`: pointers, count, `dropped`, `triggered` and post counter go to 0. Next state is CAPTURE if `en` = 1, else IDLE. `clear` has priority over a same-cycle push and pop.
- `dropped` saturates at 16'hFFFF.

## Timing
- Reset values: state IDLE; count 0; `rd_valid`, `full`, `triggered`, `done` all 0; `dropped` 0; `rd_*` 0. Memory contents are not reset.
- Pushed entry is visible on `rd_*` one cycle after the capturing edge. No combinational path from `pc_i`/`we_i` to `rd_*`.
- `rd_*` is combinational from the head pointer. A pop takes effect at the edge; the new head is visible the same cycle after the edge.
- Trigger compare uses the same-cycle `pc_i`. The trigger-cycle write is captured and counts toward `post_cnt`.
- `rst` asserted mid-capture returns all outputs to their reset values asynchronously.

## Structure
- Shared package `trace_pkg`:
  - mode encoding constants
  - state enum (IDLE, CAPTURE, POST, DONE)
  - entry struct {pc, inst, waddr, wdata, port}
  - helper function computing entry width from the parameters
- Sub-module `trace_ring`: DEPTH-entry circular buffer with push, pop and overwrite-when-full, exposing head entry, count and full.
- Top level holds the port arbiter/filter, the FSM, the post counter and the `dropped` counter.

## Test plan
- WRAP, DEPTH = 4, 6 pushes with waddr 1..6, no pops → count = 4, head waddr = 3; popping all yields waddr 3,4,5,6; `dropped` = 0.
- STOP_FULL, DEPTH = 4, 5 pushes → `done` = 1 after the 4th push; the 5th push is ignored and `dropped` = 0; count stays 4 through pops until drained.
- TRIGGER, `trig_pc` = 32'h0000_0040, `post_cnt` = 2, a write every cycle with pc 0x30, 0x34, … → `triggered` rises at pc 0x40; `done` after the push at pc 0x44; the last entry has pc 0x44.
- NPORT = 2, both ports write (waddr 5 and 7) in the same cycle → one entry with rd_port = 0 and waddr 5; `dropped` = 1. A write to r0 with FILTER_R0 = 1 → no entry.
- Full buffer with simultaneous push and pop for 3 cycles → count stays DEPTH and the popped sequence stays in order. `clear` in that same cycle → count = 0, `rd_valid` = 0 next cycle.
- `rst` pulsed while in POST → all outputs at reset values immediately. After release with `en` = 1, the block re-enters CAPTURE with `triggered` = 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the register-file write-back trace buffer:
// mode codes, capture FSM states, default entry layout and width helpers.
package trace_pkg;

    localparam logic [1:0] MODE_WRAP      = 2'd0;
    localparam logic [1:0] MODE_STOP_FULL = 2'd1;
    localparam logic [1:0] MODE_TRIGGER   = 2'd2;
    localparam logic [1:0] MODE_RSVD      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_RADDR_W = 5;
    localparam int DEF_PORT_W  = 1;

    // Entry layout for the default openmips configuration (one traced port).
    typedef struct packed {
        logic [DEF_DATA_W-1:0]  pc;
        logic [DEF_DATA_W-1:0]  inst;
        logic [DEF_RADDR_W-1:0] waddr;
        logic [DEF_DATA_W-1:0]  wdata;
        logic [DEF_PORT_W-1:0]  port;
    } entry_t;

    function automatic int port_width(input int nport);
        return (nport > 1) ? $clog2(nport) : 1;
    endfunction

    function automatic int entry_width(input int data_w, input int raddr_w, input int nport);
        return 3 * data_w + raddr_w + port_width(nport);
    endfunction

endpackage

// File: rtl/trace_ring.sv
// DEPTH-entry circular buffer. A push into a full ring overwrites the oldest
// entry; the head entry is read combinationally and reads as zero when empty.
module trace_ring #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          pop_ok;
    logic          is_full;

    assign is_full = (count_reg == FULL_COUNT);
    assign pop_ok  = pop && (count_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            // A lone push into a full ring drags the head along (overwrite).
            if (pop_ok || (push && is_full)) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop_ok && !is_full) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && pop_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;
    assign full  = is_full;

endmodule

// File: rtl/regfile_trace_buffer.sv
// Write-back trace capture: arbitrates the traced register write ports, runs
// the free-run / stop-when-full / pc-trigger capture FSM and feeds the ring.
module regfile_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RADDR_W   = 5,
    parameter int DEPTH     = 64,
    parameter int NPORT     = 1,
    parameter int FILTER_R0 = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         clear,
    input  logic [DATA_W-1:0]            trig_pc,
    input  logic [$clog2(DEPTH):0]       post_cnt,
    input  logic [DATA_W-1:0]            pc_i,
    input  logic [DATA_W-1:0]            inst_i,
    input  logic [NPORT-1:0]             we_i,
    input  logic [NPORT*RADDR_W-1:0]     waddr_i,
    input  logic [NPORT*DATA_W-1:0]      wdata_i,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [DATA_W-1:0]            rd_pc,
    output logic [DATA_W-1:0]            rd_inst,
    output logic [DATA_W-1:0]            rd_wdata,
    output logic [RADDR_W-1:0]           rd_waddr,
    output logic [port_width(NPORT)-1:0] rd_port,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         triggered,
    output logic                         done,
    output logic [15:0]                  dropped
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = port_width(NPORT);
    localparam int EW = entry_width(DATA_W, RADDR_W, NPORT);
    localparam logic [CW-1:0] LAST_FILL = CW'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  inst;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
        logic [PW-1:0]      port;
    } rec_t;

    logic [NPORT-1:0]   qual;
    logic               any_qual;
    logic [PW-1:0]      sel_port;
    logic [RADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [2:0]         nqual;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_qual
            assign qual[gi] = we_i[gi] &&
                ((FILTER_R0 == 0) || (waddr_i[gi*RADDR_W +: RADDR_W] != '0));
        end
    endgenerate

    // Scan from the top so the lowest qualified port wins.
    always_comb begin
        any_qual  = 1'b0;
        sel_port  = '0;
        sel_waddr = '0;
        sel_wdata = '0;
        nqual     = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            nqual = nqual + {2'b00, qual[k]};
            if (qual[k]) begin
                any_qual  = 1'b1;
                sel_port  = PW'(k);
                sel_waddr = waddr_i[k*RADDR_W +: RADDR_W];
                sel_wdata = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    state_t        state_reg, state_next;
    logic [CW-1:0] post_reg, post_next;
    logic          triggered_reg, triggered_next;
    logic [15:0]   dropped_reg, dropped_next;
    logic          push;
    logic          pop;
    logic          trig_hit;
    logic [16:0]   dropped_sum;
    logic [CW-1:0] ring_count;
    logic          ring_full;
    rec_t          push_rec;
    rec_t          head_rec;

    assign pop         = rd_valid && rd_ready;
    assign trig_hit    = (mode == MODE_TRIGGER) && (pc_i == trig_pc);
    assign dropped_sum = {1'b0, dropped_reg} + {14'b0, nqual - 3'd1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            post_reg      <= '0;
            triggered_reg <= 1'b0;
            dropped_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            post_reg      <= post_next;
            triggered_reg <= triggered_next;
            dropped_reg   <= dropped_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        post_next      = post_reg;
        triggered_next = triggered_reg;
        dropped_next   = dropped_reg;
        push           = ((state_reg == ST_CAPTURE) || (state_reg == ST_POST)) && any_qual;

        case (state_reg)
            ST_IDLE: begin
                if (en) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (trig_hit) begin
                    triggered_next = 1'b1;
                    if (post_cnt == '0) begin
                        push       = 1'b0;
                        post_next  = '0;
                        state_next = ST_DONE;
                    end else begin
                        // The trigger-cycle write is already one of the post captures.
                        post_next  = post_cnt - CW'(push);
                        state_next = (post_next == '0) ? ST_DONE : ST_POST;
                    end
                end else if (mode == MODE_STOP_FULL) begin
                    if (ring_full && !pop) begin
                        push       = 1'b0;
                        state_next = ST_DONE;
                    end else if (push && !pop && (ring_count == LAST_FILL)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_POST: begin
                if (push) post_next = post_reg - 1'b1;
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (push && (post_reg == CW'(1))) begin
                    state_next = ST_DONE;
                end
            end
            default: ;
        endcase

        if (push) begin
            dropped_next = dropped_sum[16] ? 16'hFFFF : dropped_sum[15:0];
        end

        if (clear) begin
            state_next     = en ? ST_CAPTURE : ST_IDLE;
            post_next      = '0;
            triggered_next = 1'b0;
            dropped_next   = '0;
        end
    end

    assign push_rec = '{pc: pc_i, inst: inst_i, waddr: sel_waddr, wdata: sel_wdata, port: sel_port};

    trace_ring #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (push_rec),
        .head  (head_rec),
        .count (ring_count),
        .full  (ring_full)
    );

    assign rd_valid  = (ring_count != '0);
    assign rd_pc     = head_rec.pc;
    assign rd_inst   = head_rec.inst;
    assign rd_waddr  = head_rec.waddr;
    assign rd_wdata  = head_rec.wdata;
    assign rd_port   = head_rec.port;
    assign count     = ring_count;
    assign full      = ring_full;
    assign triggered = triggered_reg;
    assign done      = (state_reg == ST_DONE);
    assign dropped   = dropped_reg;

endmodule
